// File: rtl/ed_stream_gen.sv
// Squared-Euclidean-distance streamer: scans nodes 0..n-1 against the query and emits (index, distance) pairs.
// Latency: 2 cycles from node issue to output pair, one node per clock.
// Backpressure: none; the consumer must accept every cycle that enable is high.
module ed_stream_gen #(
    parameter int N_NODES = 16,
    parameter int DIM     = 4,
    parameter int DW      = 8,
    localparam int NW     = $clog2(N_NODES),
    localparam int DIMW   = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [NW-1:0]   wr_node,
    input  logic [DIMW-1:0] wr_dim,
    input  logic [DW-1:0]   wr_data,
    input  logic [NW:0]     n_active,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            enable,
    output logic [31:0]     node_out,
    output logic [31:0]     ED_out
);

    localparam int SUMW = 2*DW + $clog2(DIM);
    localparam logic [NW:0] NMAX = (NW+1)'(N_NODES);
    localparam logic [NW:0] ONE  = (NW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [NW:0]     n_q, n_d, k_q, k_d, n_clip;
    logic            busy_q, busy_d, done_q, done_d;
    logic            issue;
    logic [NW-1:0]   rd_idx;

    logic [DW-1:0]   node_tbl [N_NODES][DIM];
    logic [DW-1:0]   qry      [DIM];

    logic [DW:0]     diff [DIM];
    logic [2*DW-1:0] dx   [DIM];
    logic [2*DW-1:0] sq_d [DIM];
    logic [2*DW-1:0] sq_q [DIM];
    logic            s1_vld;
    logic [NW-1:0]   s1_idx;
    logic [SUMW-1:0] sum_d;

    logic            en_q;
    logic [31:0]     node_q, ed_q;

    assign n_clip = (n_active > NMAX) ? NMAX : n_active;
    assign rd_idx = k_q[NW-1:0];

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    n_d = n_clip;
                    k_d = '0;
                    if (n_clip == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (k_q < n_q) begin
                    issue = 1'b1;
                    k_d   = k_q + ONE;
                end else begin
                    // last node is in stage 1; DONE covers the stage-2 drain
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                // an empty run shows busy alongside its done pulse
                busy_d  = (n_q == '0);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Coordinate storage is frozen while a run is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NODES; i++) begin
                for (int d = 0; d < DIM; d++) begin
                    node_tbl[i][d] <= '0;
                end
            end
            for (int d = 0; d < DIM; d++) begin
                qry[d] <= '0;
            end
        end else if (wr_en && !busy_q) begin
            if (wr_sel) begin
                qry[wr_dim] <= wr_data;
            end else begin
                node_tbl[wr_node][wr_dim] <= wr_data;
            end
        end
    end

    // Squares are computed modulo 2^(2*DW); the true value (<= 255^2) always fits.
    always_comb begin
        for (int d = 0; d < DIM; d++) begin
            diff[d] = {node_tbl[rd_idx][d][DW-1], node_tbl[rd_idx][d]}
                    - {qry[d][DW-1], qry[d]};
            dx[d]   = {{(DW-1){diff[d][DW]}}, diff[d]};
            sq_d[d] = dx[d] * dx[d];
        end
    end

    always_comb begin
        sum_d = '0;
        for (int d = 0; d < DIM; d++) begin
            sum_d = sum_d + SUMW'(sq_q[d]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_idx <= '0;
            for (int d = 0; d < DIM; d++) begin
                sq_q[d] <= '0;
            end
            en_q   <= 1'b0;
            node_q <= '0;
            ed_q   <= '0;
        end else begin
            s1_vld <= issue;
            s1_idx <= rd_idx;
            for (int d = 0; d < DIM; d++) begin
                sq_q[d] <= sq_d[d];
            end
            en_q <= s1_vld;
            if (s1_vld) begin
                node_q <= 32'(s1_idx);
                ed_q   <= 32'(sum_d);
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign enable   = en_q;
    assign node_out = node_q;
    assign ED_out   = ed_q;

endmodule

// File: tb/tb_ed_stream_gen.sv
// Directed bench for ed_stream_gen with hand-computed expected pairs and control timing.
// Latency: checks every output one step after each rising edge.
// Backpressure: n/a, the DUT stream has no ready.
module tb_ed_stream_gen;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_node;
    logic [1:0]  wr_dim;
    logic [7:0]  wr_data;
    logic [4:0]  n_active;
    logic        start;
    logic        busy;
    logic        done;
    logic        enable;
    logic [31:0] node_out;
    logic [31:0] ED_out;

    int vectors;
    int miscompares;

    ed_stream_gen #(.N_NODES(16), .DIM(4), .DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_node  (wr_node),
        .wr_dim   (wr_dim),
        .wr_data  (wr_data),
        .n_active (n_active),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .enable   (enable),
        .node_out (node_out),
        .ED_out   (ED_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ctrl(input string tag, input logic b, input logic d, input logic e);
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".enable"}, 32'(enable), 32'(e));
    endtask

    task automatic pair(input string tag, input logic [31:0] n, input logic [31:0] ed);
        chk({tag, ".node"}, node_out, n);
        chk({tag, ".ed"}, ED_out, ed);
    endtask

    task automatic wr(input logic sel, input logic [3:0] node, input logic [1:0] dim,
                      input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_node = node;
        wr_dim  = dim;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wr_pt(input logic sel, input logic [3:0] node,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        wr(sel, node, 2'd0, a);
        wr(sel, node, 2'd1, b);
        wr(sel, node, 2'd2, c);
        wr(sel, node, 2'd3, d);
    endtask

    // Leaves the bench 1 ns after E0, the edge that samples start.
    task automatic go(input logic [4:0] n);
        n_active = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        logic [9:0] exp_en;
        logic [9:0] exp_done;
        logic       seen;
        logic [31:0] exp_ed;

        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_sel   = 1'b0;
        wr_node  = '0;
        wr_dim   = '0;
        wr_data  = '0;
        n_active = '0;
        start    = 1'b0;

        repeat (2) tick();
        ctrl("reset", 1'b0, 1'b0, 1'b0);
        pair("reset", 0, 0);
        rst = 1'b0;
        tick();

        // Basic run: expected pairs (0,0) (1,30) (2,1)
        wr_pt(1'b1, 4'd0, 8'd1, 8'd2, 8'd3, 8'd4);
        wr_pt(1'b0, 4'd0, 8'd1, 8'd2, 8'd3, 8'd4);
        wr_pt(1'b0, 4'd1, 8'd0, 8'd0, 8'd0, 8'd0);
        wr_pt(1'b0, 4'd2, 8'd2, 8'd2, 8'd3, 8'd4);
        go(5'd3);
        ctrl("basic_e0", 1'b1, 1'b0, 1'b0);
        tick();
        ctrl("basic_e1", 1'b1, 1'b0, 1'b0);
        tick();
        ctrl("basic_e2", 1'b1, 1'b0, 1'b1);
        pair("basic_p0", 0, 0);
        tick();
        ctrl("basic_e3", 1'b1, 1'b0, 1'b1);
        pair("basic_p1", 1, 30);
        tick();
        ctrl("basic_e4", 1'b1, 1'b0, 1'b1);
        pair("basic_p2", 2, 1);
        tick();
        ctrl("basic_e5", 1'b0, 1'b1, 1'b0);
        pair("basic_hold", 2, 1);
        tick();
        ctrl("basic_e6", 1'b0, 1'b0, 1'b0);

        // Width extreme: 4 * 255^2 = 260100
        wr_pt(1'b1, 4'd0, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
        wr_pt(1'b0, 4'd0, 8'h80, 8'h80, 8'h80, 8'h80);
        go(5'd1);
        tick();
        ctrl("wide_e1", 1'b1, 1'b0, 1'b0);
        tick();
        ctrl("wide_e2", 1'b1, 1'b0, 1'b1);
        pair("wide_p0", 0, 260100);
        tick();
        ctrl("wide_e3", 1'b0, 1'b1, 1'b0);
        tick();
        ctrl("wide_e4", 1'b0, 1'b0, 1'b0);

        // Empty run
        go(5'd0);
        ctrl("empty_e0", 1'b0, 1'b0, 1'b0);
        tick();
        ctrl("empty_e1", 1'b1, 1'b1, 1'b0);
        tick();
        ctrl("empty_e2", 1'b0, 1'b0, 1'b0);
        pair("empty_hold", 0, 260100);

        // Oversized n_active clips to 16 nodes; query is 127s, node1/3..15 are 0
        go(5'd31);
        tick();
        ctrl("clip_e1", 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            tick();
            exp_ed = (k == 0) ? 32'd260100 : (k == 2) ? 32'd61755 : 32'd64516;
            chk("clip.enable", 32'(enable), 32'd1);
            pair("clip_pk", k, exp_ed);
        end
        tick();
        ctrl("clip_end", 1'b0, 1'b1, 1'b0);
        pair("clip_hold", 15, 64516);
        tick();

        // Busy protection: restart and write of node1 during RUN are dropped
        go(5'd2);
        n_active = 5'd2;
        start    = 1'b1;
        wr_en    = 1'b1;
        wr_sel   = 1'b0;
        wr_node  = 4'd1;
        wr_dim   = 2'd0;
        wr_data  = 8'h7F;
        tick();
        wr_en = 1'b0;
        ctrl("prot_e1", 1'b1, 1'b0, 1'b0);
        tick();
        ctrl("prot_e2", 1'b1, 1'b0, 1'b1);
        pair("prot_p0", 0, 260100);
        tick();
        ctrl("prot_e3", 1'b1, 1'b0, 1'b1);
        pair("prot_p1", 1, 64516);
        start = 1'b0;
        tick();
        ctrl("prot_e4", 1'b0, 1'b1, 1'b0);
        tick();
        ctrl("prot_e5", 1'b0, 1'b0, 1'b0);
        tick();
        ctrl("prot_e6", 1'b0, 1'b0, 1'b0);
        go(5'd2);
        repeat (3) tick();
        pair("prot_rerun_p1", 1, 64516);
        repeat (2) tick();

        // Back-to-back with start held: windows at E0+2..3 and E0+7..8
        exp_en   = 10'b01_1000_1100;
        exp_done = 10'b10_0001_0000;
        n_active = 5'd2;
        start    = 1'b1;
        tick();
        for (int j = 1; j <= 9; j++) begin
            tick();
            chk("b2b.enable", 32'(enable), 32'(exp_en[j]));
            chk("b2b.done", 32'(done), 32'(exp_done[j]));
            if (j == 7) pair("b2b_r2p0", 0, 260100);
            if (j == 8) pair("b2b_r2p1", 1, 64516);
        end
        start = 1'b0;
        tick();

        // Asynchronous reset mid-window
        go(5'd4);
        repeat (3) tick();
        chk("mid.enable_before", 32'(enable), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        ctrl("mid_rst", 1'b0, 1'b0, 1'b0);
        pair("mid_rst", 0, 0);
        @(posedge clk);
        #3;
        rst  = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            seen = seen | done | enable | busy;
        end
        chk("mid.quiet_after", 32'(seen), 32'd0);

        // Cleared table: every distance is 0
        go(5'd4);
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("clr.enable", 32'(enable), 32'd1);
            pair("clr_pk", k, 0);
        end
        tick();
        ctrl("clr_end", 1'b0, 1'b1, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ed_stream_gen.md
# ed_stream_gen

Euclidean-distance stream generator, directly upstream of the two-minimum finder stage. Holds a small table of candidate node points and one query point, computes the squared Euclidean distance from the query to each active node, and streams (node index, distance) pairs one per cycle under a single contiguous `enable` window. It is built so that the consumer's per-window minima are exactly the two nearest nodes. Fully pipelined: one node per clock, 2-cycle latency.

## Interface

- `N_NODES`, 16, number of stored candidate points (power of 2, ≥2)
- `DIM`, 4, coordinates per point (power of 2, 1..8)
- `DW`, 8, signed coordinate width (≤8)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `wr_en`  in  1  coordinate write strobe
- `wr_sel`  in  1  0 = node table, 1 = query register
- `wr_node`  in  log2(N_NODES)  node index (ignored when `wr_sel`=1)
- `wr_dim`  in  log2(DIM)  coordinate index
- `wr_data`  in  DW  signed coordinate value
- `n_active`  in  log2(N_NODES)+1  nodes to scan (0..N_NODES), sampled with `start`
- `start`  in  1  run request, level-sampled
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle end-of-run pulse
- `enable`  out  1  stream window; high exactly for the valid pairs
- `node_out`  out  32  node index, zero-extended
- `ED_out`  out  32  squared distance, zero-extended

## Operation

- Storage: N_NODES×DIM node table plus DIM-entry query register, all DW signed; all cleared to 0 by `rst`.
- Writes: one coordinate per cycle on `wr_en` while `busy`=0. Writes while `busy`=1 are dropped and the table stays frozen for the run.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start`=1 → latch n = min(`n_active`, N_NODES), node counter k=0 → RUN. If n=0 → DONE directly.
  - RUN: issue node k each cycle, k increments; after issuing node n−1 → drain the pipeline, then DONE.
  - DONE: pulse `done` one cycle → IDLE.
- `start` outside IDLE is ignored (no queueing).
- Arithmetic per coordinate: diff = node − query, DW+1 bits signed; square into 2·DW unsigned (max 255² = 65025 fits 16 bits). Sum DIM squares unsigned with no truncation (≤ 2·DW + log2(DIM) bits), then zero-extend to 32.
- Nodes stream in ascending index 0..n−1. Ties are passed through unchanged; ordering is the consumer's concern.
- Reset, asynchronous, at any time including mid-run:
  - FSM → IDLE; pipeline valids cleared.
  - `busy`, `done`, `enable`, `node_out`, `ED_out` all 0.
  - Table and query cleared.

## Timing

- Edge E0 samples `start`=1 in IDLE. `busy`=1 from E0.
- Pipeline stage 1: squares registered at E0+1+k. Stage 2: sum, node index and valid registered at E0+2+k.
- `enable`=1 from E0+2 through E0+1+n, i.e. exactly n consecutive cycles. `node_out`/`ED_out` hold pair k during the cycle after E0+2+k.
- `enable` falls at E0+2+n. On that same edge `done` rises for exactly one cycle and `busy` falls.
- Outside the window, `node_out`/`ED_out` hold the last pair; they are 0 after reset.
- n=0: `busy` and `done` rise at E0+1; `done` clears at E0+2; `busy` clears at E0+2; `enable` is never asserted.
- Back-to-back: a `start` sampled during the `done` cycle (IDLE at that edge) is accepted. The next window opens 3 edges later, so `enable` stays low ≥3 cycles between windows and the consumer sees a falling edge per run.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan

- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately. A subsequent run with n=4 streams ED=0 for every node (table cleared).
- Basic run, DIM=4:
  - Setup: query (1,2,3,4); node0 (1,2,3,4); node1 (0,0,0,0); node2 (2,2,3,4); `n_active`=3.
  - Expect: `enable` high cycles E0+2..E0+4 with pairs (0,0), (1,30), (2,1).
  - Expect: `done` pulses at E0+5.
- Width extreme: query (127,127,127,127), node0 (−128,−128,−128,−128), n=1 → ED_out=260100, `node_out`=0, `enable` high for exactly one cycle.
- Boundaries:
  - n=0 → no `enable`, `done` at E0+1.
  - `n_active`=31 with N_NODES=16 → exactly 16 pairs, indices 0..15.
- Busy protection:
  - `start` re-asserted and `wr_en` writing node1 during RUN → single window only.
  - node1 ED unchanged; a following run still shows the old value.
- Back-to-back plus reset:
  - `start` held high continuously → windows separated by exactly 3 low cycles, identical data each run.
  - `rst` pulsed at E0+3 → `enable`/`busy` drop immediately and no `done` pulse occurs.
